tx_port_arbiter: RTL

- Shares one tx engine write-request path among C_NUM_CHNL tx_port_128 instances.
- Arbitrates each channel's TX_REQ/TX_ADDR/TX_LEN with round-robin priority.
- Forwards the winner to the engine and routes TX_DATA_REN/TX_DATA and TX_SENT back to that channel.
- Only one write is outstanding at a time; the grant is held from request until TX_SENT.

---
 rtl/tx_port_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/tx_port_arbiter.sv
// tx_port_arbiter
// Shares one tx engine write-request path among C_NUM_CHNL tx ports.
// Requests are granted round-robin. Only one write is outstanding at a time.
// The grant is held from the engine request until the engine reports the write sent.
module tx_port_arbiter #(
  parameter int  C_NUM_CHNL   = 4,
  parameter int  C_DATA_WIDTH = 128,
  localparam int C_CHNL_WIDTH = (C_NUM_CHNL > 1) ? $clog2(C_NUM_CHNL) : 1
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [C_NUM_CHNL-1:0]              TX_REQ,
  output logic [C_NUM_CHNL-1:0]              TX_REQ_ACK,
  input  logic [64*C_NUM_CHNL-1:0]           TX_ADDR,
  input  logic [10*C_NUM_CHNL-1:0]           TX_LEN,
  input  logic [C_DATA_WIDTH*C_NUM_CHNL-1:0] TX_DATA,
  output logic [C_NUM_CHNL-1:0]              TX_DATA_REN,
  output logic [C_NUM_CHNL-1:0]              TX_SENT,
  output logic                               ENG_REQ,
  input  logic                               ENG_REQ_ACK,
  output logic [63:0]                        ENG_ADDR,
  output logic [9:0]                         ENG_LEN,
  output logic [C_CHNL_WIDTH-1:0]            ENG_CHNL,
  output logic [C_DATA_WIDTH-1:0]            ENG_DATA,
  input  logic                               ENG_DATA_REN,
  input  logic                               ENG_SENT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [C_CHNL_WIDTH-1:0] ptr_reg, ptr_next;
  logic [C_CHNL_WIDTH-1:0] chnl_reg;
  logic [63:0]             addr_reg;
  logic [9:0]              len_reg;

  // Round-robin search: requests at or above the pointer take precedence.
  // The lowest set bit of that group wins. If the group is empty, the lowest
  // request overall wins, which is the wrap-around case.
  logic [C_NUM_CHNL-1:0]   hi_req;
  logic [C_NUM_CHNL-1:0]   hi_first;
  logic [C_NUM_CHNL-1:0]   all_first;
  logic [C_NUM_CHNL-1:0]   grant_onehot;
  logic                    any_req;
  logic [C_CHNL_WIDTH-1:0] grant_idx;
  logic [63:0]             grant_addr;
  logic [9:0]              grant_len;

  // One-hot decode of the currently held channel.
  // This decode steers the data mux and every per-channel output.
  logic [C_NUM_CHNL-1:0]   chnl_sel;

  // Transposed AND-OR mux terms.
  // Each output bit is an OR-reduction across channels.
  logic [C_CHNL_WIDTH-1:0][C_NUM_CHNL-1:0] idx_mask;
  logic [63:0][C_NUM_CHNL-1:0]             addr_col;
  logic [9:0][C_NUM_CHNL-1:0]              len_col;
  logic [C_DATA_WIDTH-1:0][C_NUM_CHNL-1:0] data_col;

  assign any_req      = |TX_REQ;
  assign hi_first     = hi_req & (~hi_req + 1'b1);
  assign all_first    = TX_REQ & (~TX_REQ + 1'b1);
  assign grant_onehot = (|hi_req) ? hi_first : all_first;

  for (genvar gi = 0; gi < C_NUM_CHNL; gi++) begin : g_chnl
    assign hi_req[gi]   = TX_REQ[gi] && (C_CHNL_WIDTH'(gi) >= ptr_reg);
    assign chnl_sel[gi] = (chnl_reg == C_CHNL_WIDTH'(gi));

    for (genvar gb = 0; gb < C_CHNL_WIDTH; gb++) begin : g_idx
      assign idx_mask[gb][gi] = (((gi >> gb) % 2) == 1);
    end
    for (genvar gb = 0; gb < 64; gb++) begin : g_addr
      assign addr_col[gb][gi] = grant_onehot[gi] & TX_ADDR[64*gi + gb];
    end
    for (genvar gb = 0; gb < 10; gb++) begin : g_len
      assign len_col[gb][gi] = grant_onehot[gi] & TX_LEN[10*gi + gb];
    end
    for (genvar gb = 0; gb < C_DATA_WIDTH; gb++) begin : g_data
      assign data_col[gb][gi] = chnl_sel[gi] & TX_DATA[C_DATA_WIDTH*gi + gb];
    end
  end

  for (genvar gb = 0; gb < C_CHNL_WIDTH; gb++) begin : g_idx_or
    assign grant_idx[gb] = |(grant_onehot & idx_mask[gb]);
  end
  for (genvar gb = 0; gb < 64; gb++) begin : g_addr_or
    assign grant_addr[gb] = |addr_col[gb];
  end
  for (genvar gb = 0; gb < 10; gb++) begin : g_len_or
    assign grant_len[gb] = |len_col[gb];
  end

  // ENG_DATA follows the held channel at all times.
  // This way the first beat is already valid when the engine raises its read enable.
  for (genvar gb = 0; gb < C_DATA_WIDTH; gb++) begin : g_data_or
    assign ENG_DATA[gb] = |data_col[gb];
  end

  assign ENG_ADDR = addr_reg;
  assign ENG_LEN  = len_reg;
  assign ENG_CHNL = chnl_reg;

  // State register and round-robin priority pointer
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  // Grant capture: index, address and length are sampled once when granted
  always_ff @(posedge CLK) begin
    if (RST) begin
      chnl_reg <= '0;
      addr_reg <= '0;
      len_reg  <= '0;
    end else if (state_reg == ST_IDLE && any_req) begin
      chnl_reg <= grant_idx;
      addr_reg <= grant_addr;
      len_reg  <= grant_len;
    end
  end

  // Next-state logic.
  // The pointer only advances on a completed write, so a withdrawn request leaves it untouched.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (any_req) state_next = ST_REQ;
      end
      ST_REQ: begin
        if (ENG_REQ_ACK)               state_next = ST_XFER;
        else if (!(|(TX_REQ & chnl_sel))) state_next = ST_IDLE;
      end
      ST_XFER: begin
        if (ENG_SENT) begin
          state_next = ST_IDLE;
          ptr_next   = (chnl_reg == C_CHNL_WIDTH'(C_NUM_CHNL - 1)) ? '0 : chnl_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs: the engine request plus per-channel strobes routed only to the held channel
  always_comb begin
    ENG_REQ     = 1'b0;
    TX_REQ_ACK  = '0;
    TX_DATA_REN = '0;
    TX_SENT     = '0;
    case (state_reg)
      ST_REQ: begin
        ENG_REQ = 1'b1;
        if (ENG_REQ_ACK) TX_REQ_ACK = chnl_sel;
      end
      ST_XFER: begin
        if (ENG_DATA_REN) TX_DATA_REN = chnl_sel;
        if (ENG_SENT)     TX_SENT     = chnl_sel;
      end
      default: ;
    endcase
  end

endmodule
